// File: rtl/delay_line_ram.sv
// Circular-buffer delay line with NUM_TAPS independently addressed read taps.
// Every enabled cycle writes one sample, reads every tap before the write, and
// reports the sample being overwritten. Each output is masked to zero until the
// buffer holds enough real history to serve it.
module delay_line_ram #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_TAPS      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic [NUM_TAPS*ADDRESS_WIDTH-1:0] delay,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]    tap_out,
  output logic [NUM_TAPS-1:0]               tap_valid,
  output logic [DATA_WIDTH-1:0]             dout_evict,
  output logic                              evict_valid,
  output logic                              full
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  // DEPTH expressed in the fill counter's width (one bit wider than an address).
  localparam logic [ADDRESS_WIDTH:0] DEPTH_V = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  // Sample storage; deliberately not reset, stale contents are masked by the valid rules.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDRESS_WIDTH-1:0]          wr_ptr_q,      wr_ptr_d;
  logic [ADDRESS_WIDTH:0]            fill_q,        fill_d;
  logic [NUM_TAPS*DATA_WIDTH-1:0]    tap_out_q,     tap_out_d;
  logic [NUM_TAPS-1:0]               tap_valid_q,   tap_valid_d;
  logic [DATA_WIDTH-1:0]             dout_evict_q,  dout_evict_d;
  logic                              evict_valid_q, evict_valid_d;

  logic [NUM_TAPS*DATA_WIDTH-1:0]    tap_nxt;
  logic [NUM_TAPS-1:0]               tap_vld_nxt;
  logic                              buf_full;

  // Fill count saturates once the buffer has wrapped at least once.
  function automatic logic [ADDRESS_WIDTH:0] fill_sat_inc(input logic [ADDRESS_WIDTH:0] f);
    return (f == DEPTH_V) ? f : f + 1'b1;
  endfunction

  assign buf_full = (fill_q == DEPTH_V);

  // Per-tap read: delay 0 is write-through, otherwise read d samples back; the
  // subtraction wraps naturally in ADDRESS_WIDTH bits so any delay is in range.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    logic [ADDRESS_WIDTH-1:0] d;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     vld;
    logic [DATA_WIDTH-1:0]    data;

    assign d       = delay[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign rd_addr = wr_ptr_q - d;
    assign vld     = (d == '0) || ({1'b0, d} <= fill_q);
    assign data    = !vld      ? '0  :
                     (d == '0) ? din :
                                 mem[rd_addr];

    assign tap_nxt[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign tap_vld_nxt[k]                      = vld;
  end

  // Next-state: everything advances only on a sample strobe, otherwise holds.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    tap_out_d     = tap_out_q;
    tap_valid_d   = tap_valid_q;
    dout_evict_d  = dout_evict_q;
    evict_valid_d = evict_valid_q;
    if (en) begin
      wr_ptr_d      = wr_ptr_q + 1'b1;
      fill_d        = fill_sat_inc(fill_q);
      tap_out_d     = tap_nxt;
      tap_valid_d   = tap_vld_nxt;
      evict_valid_d = buf_full;
      dout_evict_d  = buf_full ? mem[wr_ptr_q] : '0;
    end
  end

  // Control and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      tap_out_q     <= '0;
      tap_valid_q   <= '0;
      dout_evict_q  <= '0;
      evict_valid_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      tap_out_q     <= tap_out_d;
      tap_valid_q   <= tap_valid_d;
      dout_evict_q  <= dout_evict_d;
      evict_valid_q <= evict_valid_d;
    end
  end

  // Memory write; reads above see the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign tap_out     = tap_out_q;
  assign tap_valid   = tap_valid_q;
  assign dout_evict  = dout_evict_q;
  assign evict_valid = evict_valid_q;
  assign full        = buf_full;

endmodule

// File: doc/delay_line_ram.md
DELAY_LINE_RAM -- requirements
Module: delay_line_ram

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 8, meaning log2 of circular buffer depth (DEPTH = 2**ADDRESS_WIDTH).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning sample width.
REQ-003 The block SHALL have parameter NUM_TAPS, default 2, meaning number of independent read taps (1..8).
REQ-004 One clock, reset asynchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  sample strobe; one write and all tap reads per cycle when high.
REQ-008 din  input  DATA_WIDTH  sample written when en high.
REQ-009 delay  input  NUM_TAPS*ADDRESS_WIDTH  packed per-tap delay in samples; tap k uses bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-010 tap_out  output  NUM_TAPS*DATA_WIDTH  packed registered tap samples, same packing as delay.
REQ-011 tap_valid  output  NUM_TAPS  per-tap flag: tap_out[k] holds real history.
REQ-012 dout_evict  output  DATA_WIDTH  registered sample overwritten by the latest write.
REQ-013 evict_valid  output  1  dout_evict holds a real overwritten sample.
REQ-014 full  output  1  buffer has held DEPTH samples since reset.

Function
REQ-015 Internal state SHALL be: memory DEPTH x DATA_WIDTH, write pointer wr_ptr (ADDRESS_WIDTH bits), fill counter fill (ADDRESS_WIDTH+1 bits, saturating at DEPTH).
REQ-016 On a rising edge with en=1: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1 modulo DEPTH (wrap 2**ADDRESS_WIDTH-1 -> 0); fill <= min(fill+1, DEPTH).
REQ-017 On the same edge, for each tap k with d=delay_k: if d==0, tap_out[k] <= din (write-through); else tap_out[k] <= mem[(wr_ptr - d) mod DEPTH], read before the write.
REQ-018 tap_valid[k] SHALL be registered on the same edge as: (d==0) or (d <= fill), using fill before the update.
REQ-019 When tap_valid[k] evaluates 0, tap_out[k] SHALL be loaded with zero, never stale memory.
REQ-020 dout_evict SHALL be loaded with mem[wr_ptr] before overwrite; evict_valid <= (fill == DEPTH) before update; dout_evict loaded with zero when evict_valid evaluates 0.
REQ-021 full SHALL be combinational (fill == DEPTH).
REQ-022 Latency: one cycle from en edge to tap_out/tap_valid/dout_evict visible; no further pipeline stages.
REQ-023 With en=0, memory, wr_ptr, fill and all registered outputs SHALL hold their values.
REQ-024 Delay changes SHALL take effect on the next en edge with no flush; different taps may share or change delays independently.
REQ-025 Maximum delay DEPTH-1 SHALL be supported; address arithmetic is ADDRESS_WIDTH-bit wrap, no out-of-range access possible.

Reset
REQ-026 While rst=1, regardless of clk: wr_ptr=0, fill=0, tap_out=0, tap_valid=0, dout_evict=0, evict_valid=0; full therefore 0.
REQ-027 Memory contents SHALL NOT be cleared by reset; stale data is masked by REQ-018..REQ-020.
REQ-028 Reset asserted mid-stream SHALL abandon history; the first en after deassertion writes address 0 and valid rules restart from fill=0.

Verification (ADDRESS_WIDTH=4, DATA_WIDTH=8, NUM_TAPS=2)
REQ-029 Reset, delay0=3, delay1=0, en=1 with din=1,2,3,...: tap1 valid from first edge equal to din; tap0 valid=0, output 0 for writes 1-3, then valid=1 with tap0 = din-3 (write 4 -> 1).
REQ-030 delay0=15, din=1..20: tap0 first valid at write 16 with value 1; write 20 -> 5; full rises after write 16.
REQ-031 din=1..20 continuous: evict_valid=0 through write 16; write 17 -> dout_evict=1, write 20 -> 4 (wrap of wr_ptr 15->0 checked).
REQ-032 After 8 writes, hold en=0 for 5 cycles with din toggling: all outputs and full unchanged; next en resumes at address 8.
REQ-033 After 10 writes assert rst asynchronously mid-cycle: outputs zero immediately; after release, delay0=3 gives tap0 valid only from 4th new write with value of 1st new sample.
REQ-034 Change delay0 from 2 to 5 after 12 writes: next en edge returns din-5 with valid=1, no intermediate value.
